adc_spi_sequencer: RTL and testbench

//  - Sits between the NIOS II ADC PIOs and the DE0-Nano ADC128S022 SPI ADC.
//  - Consumes the 4-bit ADC command PIO: start strobe plus channel.
//  - Runs the SPI frame(s) and returns a held 12-bit sample plus a valid/channel nibble for the NIOS input PIOs.
//  - Hides the ADC pipeline quirk: the frame-n conversion uses the address sent in frame n-1.

---
 rtl/adc_spi_sequencer.sv | 170 +++++++++++++++++
 tb/tb_adc_spi_sequencer.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_spi_sequencer.sv
// ADC128S022 SPI sequencer for the DE0-Nano: turns a start strobe plus channel
// from the command PIO into one or two SPI frames and returns a held sample.
// The ADC converts the address sent in the previous frame, so a request for a
// channel other than the last addressed one runs a discarded dummy frame first.
module adc_spi_sequencer #(
  parameter int unsigned CLK_DIV = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  i_adc_cmd,
  output logic [11:0] o_adc_data,
  output logic [3:0]  o_adc_chan_valid,
  output logic        o_busy,
  output logic        o_adc_cs_n,
  output logic        o_adc_sclk,
  output logic        o_adc_mosi,
  input  logic        i_adc_miso
);

  localparam int unsigned CNT_W    = $clog2(CLK_DIV + 1);
  localparam int unsigned BIT_W    = 4;
  localparam int unsigned FRAME_W  = 16;
  localparam int unsigned DATA_W   = 12;
  localparam logic [CNT_W-1:0] HALF_LAST  = CNT_W'(CLK_DIV - 1);
  // DONE occupies one cycle of the cs_n-high gap, so QUIET runs one short
  localparam logic [CNT_W-1:0] QUIET_LAST = CNT_W'(CLK_DIV - 2);
  localparam logic [BIT_W-1:0] BIT_LAST   = BIT_W'(FRAME_W - 1);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT,
    DONE,
    QUIET
  } state_t;

  state_t               state;
  logic [CNT_W-1:0]     cnt;
  logic [BIT_W-1:0]     bit_idx;
  logic                 phase_high;
  logic [FRAME_W-1:0]   shift_reg;
  logic [2:0]           req_ch;
  logic                 dbl;
  logic [2:0]           last_addr;
  logic                 last_addr_known;
  logic                 start_q;
  logic                 miso_meta;
  logic                 miso_sync;

  // DIN value for a given bit-time: channel address on bit-times 2..4
  function automatic logic mosi_bit(input logic [BIT_W-1:0] idx, input logic [2:0] ch);
    logic b;
    b = 1'b0;
    case (idx)
      BIT_W'(2): b = ch[2];
      BIT_W'(3): b = ch[1];
      BIT_W'(4): b = ch[0];
      default:   b = 1'b0;
    endcase
    return b;
  endfunction

  // Sequencer FSM, start-edge detector and MISO synchroniser
  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= IDLE;
      cnt              <= '0;
      bit_idx          <= '0;
      phase_high       <= 1'b0;
      shift_reg        <= '0;
      req_ch           <= '0;
      dbl              <= 1'b0;
      last_addr        <= '0;
      last_addr_known  <= 1'b0;
      start_q          <= 1'b0;
      miso_meta        <= 1'b0;
      miso_sync        <= 1'b0;
      o_adc_data       <= '0;
      o_adc_chan_valid <= '0;
      o_busy           <= 1'b0;
      o_adc_cs_n       <= 1'b1;
      o_adc_sclk       <= 1'b1;
      o_adc_mosi       <= 1'b0;
    end else begin
      start_q   <= i_adc_cmd[3];
      miso_meta <= i_adc_miso;
      miso_sync <= miso_meta;

      case (state)
        IDLE: begin
          if (i_adc_cmd[3] && !start_q) begin
            req_ch              <= i_adc_cmd[2:0];
            o_busy              <= 1'b1;
            o_adc_chan_valid[3] <= 1'b0;
            o_adc_cs_n          <= 1'b0;
            o_adc_sclk          <= 1'b1;
            dbl                 <= !(last_addr_known && (last_addr == i_adc_cmd[2:0]));
            cnt                 <= '0;
            state               <= SETUP;
          end
        end

        SETUP: begin
          if (cnt == HALF_LAST) begin
            cnt        <= '0;
            bit_idx    <= '0;
            phase_high <= 1'b0;
            o_adc_sclk <= 1'b0;
            o_adc_mosi <= mosi_bit('0, req_ch);
            state      <= SHIFT;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        SHIFT: begin
          if (cnt == HALF_LAST) begin
            cnt <= '0;
            if (!phase_high) begin
              o_adc_sclk <= 1'b1;
              shift_reg  <= {shift_reg[FRAME_W-2:0], miso_sync};
              phase_high <= 1'b1;
            end else if (bit_idx == BIT_LAST) begin
              o_adc_cs_n      <= 1'b1;
              o_adc_mosi      <= 1'b0;
              last_addr       <= req_ch;
              last_addr_known <= 1'b1;
              if (!dbl) begin
                o_adc_data       <= shift_reg[DATA_W-1:0];
                o_adc_chan_valid <= {1'b1, req_ch};
              end
              state <= DONE;
            end else begin
              o_adc_sclk <= 1'b0;
              o_adc_mosi <= mosi_bit(bit_idx + BIT_W'(1), req_ch);
              bit_idx    <= bit_idx + BIT_W'(1);
              phase_high <= 1'b0;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        DONE: begin
          cnt   <= '0;
          state <= QUIET;
        end

        QUIET: begin
          if (cnt == QUIET_LAST) begin
            cnt <= '0;
            if (dbl) begin
              dbl        <= 1'b0;
              o_adc_cs_n <= 1'b0;
              state      <= SETUP;
            end else begin
              o_busy <= 1'b0;
              state  <= IDLE;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_adc_spi_sequencer.sv
// Directed bench for adc_spi_sequencer: two instances (CLK_DIV 10 and 4), each
// talking to a behavioural ADC128S022 that converts the previously sent address.
module tb_adc_spi_sequencer;

  logic        clk;
  logic        reset [2];
  logic [3:0]  cmd   [2];
  logic [11:0] data  [2];
  logic [3:0]  cv    [2];
  logic        busy  [2];
  logic        cs_n  [2];
  logic        sclk  [2];
  logic        mosi  [2];
  logic        miso  [2];
  int          sclk_tot [2];
  int          cs_tot   [2];
  logic [2:0]  addr_mdl [2];

  int n_checks = 0;
  int n_fail   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ADC conversion value for a given instance and channel
  function automatic logic [11:0] adc_val(input int g, input logic [2:0] ch);
    logic [11:0] v;
    if (g == 0) begin
      case (ch)
        3'd0: v = 12'hA5C;
        3'd1: v = 12'h3C1;
        3'd2: v = 12'h7E2;
        3'd3: v = 12'h123;
        3'd4: v = 12'h456;
        3'd5: v = 12'h9AB;
        3'd6: v = 12'hDEF;
        default: v = 12'h0F0;
      endcase
    end else begin
      v = 12'(32'(ch) * 32'h210 + 32'h00F);
    end
    return v;
  endfunction

  for (genvar g = 0; g < 2; g++) begin : gi
    localparam int unsigned DIV = (g == 0) ? 10 : 4;

    adc_spi_sequencer #(.CLK_DIV(DIV)) dut (
      .clk              (clk),
      .reset            (reset[g]),
      .i_adc_cmd        (cmd[g]),
      .o_adc_data       (data[g]),
      .o_adc_chan_valid (cv[g]),
      .o_busy           (busy[g]),
      .o_adc_cs_n       (cs_n[g]),
      .o_adc_sclk       (sclk[g]),
      .o_adc_mosi       (mosi[g]),
      .i_adc_miso       (miso[g])
    );

    logic [15:0] tx;
    logic [2:0]  din_addr;
    logic [2:0]  conv_addr = 3'd0;
    logic        miso_m = 1'b0;
    int          rise_n = 0;
    int          fall_n = 0;
    int          sclk_total = 0;
    int          cs_total = 0;

    // Frame start: load the conversion of the previously addressed channel
    always @(negedge cs_n[g]) begin
      tx       = {4'h0, adc_val(g, conv_addr)};
      miso_m   = tx[15];
      fall_n   = 0;
      rise_n   = 0;
      cs_total = cs_total + 1;
    end

    // DOUT changes on SCLK falling edges
    always @(negedge sclk[g]) begin
      if (cs_n[g] === 1'b0 && fall_n < 16) begin
        miso_m = tx[15 - fall_n];
        fall_n = fall_n + 1;
      end
    end

    // DIN captured on SCLK rising edges, address on bit-times 2..4
    always @(posedge sclk[g]) begin
      if (cs_n[g] === 1'b0) begin
        if (rise_n >= 2 && rise_n <= 4) din_addr = {din_addr[1:0], mosi[g]};
        rise_n     = rise_n + 1;
        sclk_total = sclk_total + 1;
      end
    end

    // A complete frame makes its address the next conversion channel
    always @(posedge cs_n[g]) begin
      if (rise_n == 16) conv_addr = din_addr;
      rise_n = 0;
    end

    assign miso[g]     = miso_m;
    assign sclk_tot[g] = sclk_total;
    assign cs_tot[g]   = cs_total;
    assign addr_mdl[g] = conv_addr;
  end

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Issue one request and watch it until busy falls; optional start toggle while busy
  task automatic run_req(input int g, input logic [3:0] c, input int tog_n,
                         input logic [3:0] tog_lo, input logic [3:0] tog_hi,
                         output int tv, output int tbf, output int ns, output int nc,
                         output logic b0, output logic v0);
    int s0, c0;
    s0 = sclk_tot[g];
    c0 = cs_tot[g];
    b0 = 1'b0;
    v0 = 1'b1;
    tv = -1;
    tbf = -1;
    @(negedge clk);
    cmd[g] = c;
    for (int n = 0; n < 2000; n++) begin
      @(posedge clk);
      #1;
      if (n == 0) begin
        b0 = busy[g];
        v0 = cv[g][3];
      end
      if (tog_n >= 0 && n == tog_n) cmd[g] = tog_lo;
      if (tog_n >= 0 && n == tog_n + 10) cmd[g] = tog_hi;
      if (tv < 0 && cv[g][3]) tv = n;
      if (n > 0 && !busy[g]) begin
        tbf = n;
        break;
      end
    end
    ns = sclk_tot[g] - s0;
    nc = cs_tot[g] - c0;
  endtask

  task automatic check_req(input string tag, input int g, input bit dbl,
                           input logic [11:0] d, input logic [3:0] v,
                           input int tv, input int tbf, input int ns, input int nc,
                           input logic b0, input logic v0);
    int div;
    div = (g == 0) ? 10 : 4;
    chk({tag, " busy_at_T0"}, int'(b0), 1);
    chk({tag, " valid_clr_at_T0"}, int'(v0), 0);
    chk({tag, " valid_time"}, tv, (dbl ? 67 : 33) * div);
    chk({tag, " busy_fall_time"}, tbf, (dbl ? 68 : 34) * div);
    chk({tag, " sclk_pulses"}, ns, dbl ? 32 : 16);
    chk({tag, " cs_windows"}, nc, dbl ? 2 : 1);
    chk({tag, " data"}, int'(data[g]), int'(d));
    chk({tag, " chan_valid"}, int'(cv[g]), int'(v));
    chk({tag, " adc_addr"}, int'(addr_mdl[g]), int'(v[2:0]));
  endtask

  typedef struct {
    int          g;
    logic [3:0]  c;
    bit          dbl;
    logic [11:0] d;
    logic [3:0]  v;
  } vec_t;

  vec_t vecs [14];

  initial begin
    int tv, tbf, ns, nc, s0;
    logic b0, v0;
    bit seen;

    vecs[0]  = '{0, 4'h8, 1'b1, 12'hA5C, 4'h8};
    vecs[1]  = '{0, 4'h8, 1'b0, 12'hA5C, 4'h8};
    vecs[2]  = '{0, 4'hB, 1'b1, 12'h123, 4'hB};
    vecs[3]  = '{0, 4'hB, 1'b0, 12'h123, 4'hB};
    vecs[4]  = '{0, 4'h9, 1'b1, 12'h3C1, 4'h9};
    vecs[5]  = '{1, 4'h8, 1'b1, 12'h00F, 4'h8};
    vecs[6]  = '{1, 4'h9, 1'b1, 12'h21F, 4'h9};
    vecs[7]  = '{1, 4'hA, 1'b1, 12'h42F, 4'hA};
    vecs[8]  = '{1, 4'hB, 1'b1, 12'h63F, 4'hB};
    vecs[9]  = '{1, 4'hC, 1'b1, 12'h84F, 4'hC};
    vecs[10] = '{1, 4'hD, 1'b1, 12'hA5F, 4'hD};
    vecs[11] = '{1, 4'hE, 1'b1, 12'hC6F, 4'hE};
    vecs[12] = '{1, 4'hF, 1'b1, 12'hE7F, 4'hF};
    vecs[13] = '{1, 4'hF, 1'b0, 12'hE7F, 4'hF};

    for (int g = 0; g < 2; g++) begin
      reset[g] = 1'b1;
      cmd[g]   = 4'h0;
    end
    repeat (5) @(posedge clk);
    #1;
    for (int g = 0; g < 2; g++) begin
      chk($sformatf("rst%0d cs_n", g), int'(cs_n[g]), 1);
      chk($sformatf("rst%0d sclk", g), int'(sclk[g]), 1);
      chk($sformatf("rst%0d mosi", g), int'(mosi[g]), 0);
      chk($sformatf("rst%0d data", g), int'(data[g]), 0);
      chk($sformatf("rst%0d chan_valid", g), int'(cv[g]), 0);
      chk($sformatf("rst%0d busy", g), int'(busy[g]), 0);
    end
    @(negedge clk);
    reset[0] = 1'b0;
    reset[1] = 1'b0;
    repeat (3) @(posedge clk);

    // Table-driven requests
    foreach (vecs[i]) begin
      @(negedge clk);
      cmd[vecs[i].g] = {1'b0, vecs[i].c[2:0]};
      repeat (3) @(posedge clk);
      run_req(vecs[i].g, vecs[i].c, -1, 4'h0, 4'h0, tv, tbf, ns, nc, b0, v0);
      check_req($sformatf("vec%0d", i), vecs[i].g, vecs[i].dbl, vecs[i].d, vecs[i].v,
                tv, tbf, ns, nc, b0, v0);
    end

    // Start toggled while busy: ignored, original channel completes
    @(negedge clk);
    cmd[0] = 4'h3;
    repeat (3) @(posedge clk);
    run_req(0, 4'hB, 50, 4'h5, 4'hD, tv, tbf, ns, nc, b0, v0);
    check_req("toggle", 0, 1'b1, 12'h123, 4'hB, tv, tbf, ns, nc, b0, v0);
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (busy[0]) seen = 1'b1;
    end
    chk("held_start_no_retrigger", int'(seen), 0);
    chk("held_valid", int'(cv[0]), 4'hB);

    // Establish ch0 as last address, then reset during SCLK pulse 6
    @(negedge clk);
    cmd[0] = 4'h0;
    repeat (3) @(posedge clk);
    run_req(0, 4'h8, -1, 4'h0, 4'h0, tv, tbf, ns, nc, b0, v0);
    check_req("pre_abort", 0, 1'b1, 12'hA5C, 4'h8, tv, tbf, ns, nc, b0, v0);
    @(negedge clk);
    cmd[0] = 4'h0;
    repeat (3) @(posedge clk);
    s0 = sclk_tot[0];
    @(negedge clk);
    cmd[0] = 4'h8;
    seen = 1'b0;
    for (int n = 0; n < 1000; n++) begin
      @(posedge clk);
      #1;
      if (sclk_tot[0] - s0 >= 6) begin
        seen = 1'b1;
        break;
      end
    end
    chk("abort_reached_pulse6", int'(seen), 1);
    chk("abort_busy_before", int'(busy[0]), 1);
    @(negedge clk);
    reset[0] = 1'b1;
    cmd[0]   = 4'h0;
    @(posedge clk);
    #1;
    chk("abort cs_n", int'(cs_n[0]), 1);
    chk("abort sclk", int'(sclk[0]), 1);
    chk("abort mosi", int'(mosi[0]), 0);
    chk("abort data", int'(data[0]), 0);
    chk("abort chan_valid", int'(cv[0]), 0);
    chk("abort busy", int'(busy[0]), 0);
    @(negedge clk);
    reset[0] = 1'b0;
    repeat (3) @(posedge clk);
    run_req(0, 4'h8, -1, 4'h0, 4'h0, tv, tbf, ns, nc, b0, v0);
    check_req("post_abort", 0, 1'b1, 12'hA5C, 4'h8, tv, tbf, ns, nc, b0, v0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
